// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback unit.
// Captures the memory-stage result, extends load data and selects the writeback
// source. It drives the register-file write port and the forwarding source from
// the same registers, and counts retired instructions.
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic [4:0]           in_rd_addr,
  input  logic [1:0]           in_result_src,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_mem_rdata,
  input  logic [XLEN-1:0]      in_pc_plus4,
  output logic                 RegWrite,
  output logic [4:0]           rd_addr,
  output logic [XLEN-1:0]      rd_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd_addr,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 wb_err,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // Only funct3 codes 000, 001, 010, 100 and 101 are valid load types.
  function automatic logic load_f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Picks the addressed byte or halfword from the word and extends it.
  // An illegal funct3 returns zero.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    // The low offset bit does not affect halfword selection.
    if (off[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, byte_v};
      3'b101:  res = {16'h0000, half_v};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic [XLEN-1:0]      nxt_data_s;
  logic                 nxt_err_s;
  logic                 nxt_we_s;
  logic                 valid_r;
  logic                 we_r;
  logic [4:0]           rd_addr_r;
  logic [XLEN-1:0]      rd_data_r;
  logic                 err_r;
  logic [INSTRET_W-1:0] instret_r;

  // Compute the writeback value, error flag and write enable before capture.
  always_comb begin
    nxt_data_s = '0;
    nxt_err_s  = 1'b0;
    case (in_result_src)
      SRC_ALU: nxt_data_s = in_alu_result;
      SRC_LOAD: begin
        nxt_data_s = load_extend(in_funct3, in_alu_result[1:0], in_mem_rdata);
        nxt_err_s  = in_valid & ~load_f3_legal(in_funct3);
      end
      SRC_PC4: nxt_data_s = in_pc_plus4;
      default: begin
        nxt_data_s = '0;
        nxt_err_s  = in_valid;
      end
    endcase
    if (in_valid && in_reg_write && (in_rd_addr != 5'd0) && !nxt_err_s) begin
      nxt_we_s = 1'b1;
    end else begin
      nxt_we_s = 1'b0;
    end
  end

  // Stage register: flush kills the entry, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      we_r      <= 1'b0;
      rd_addr_r <= 5'd0;
      rd_data_r <= '0;
      err_r     <= 1'b0;
    end else if (flush) begin
      valid_r   <= 1'b0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
    end else if (!stall) begin
      valid_r   <= in_valid;
      we_r      <= nxt_we_s;
      rd_addr_r <= in_rd_addr;
      rd_data_r <= nxt_data_s;
      err_r     <= nxt_err_s;
    end
  end

  // Retire counter: an entry is counted when it leaves WB without being flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= '0;
    end else if (valid_r && !stall && !flush) begin
      instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign RegWrite    = we_r;
  assign rd_addr     = rd_addr_r;
  assign rd_data     = rd_data_r;
  assign fwd_valid   = we_r;
  assign fwd_rd_addr = rd_addr_r;
  assign fwd_data    = rd_data_r;
  assign wb_err      = err_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. It queues an expected writeback record for
// each driven cycle, then pops and compares the record after the capture edge.
// A second instance with a 4-bit counter sees the same stimulus and checks
// counter wrap.
module tb_wb_stage;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;

  logic        RegWrite, fwd_valid, wb_err;
  logic [4:0]  rd_addr, fwd_rd_addr;
  logic [31:0] rd_data, fwd_data;
  logic [63:0] instret;

  logic        s_we, s_fv, s_err;
  logic [4:0]  s_addr, s_faddr;
  logic [31:0] s_data, s_fdata;
  logic [3:0]  s_instret;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic m_valid;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_result_src(in_result_src),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .RegWrite(RegWrite), .rd_addr(rd_addr), .rd_data(rd_data),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .wb_err(wb_err), .instret(instret)
  );

  wb_stage #(.XLEN(32), .INSTRET_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_result_src(in_result_src),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4), .RegWrite(s_we), .rd_addr(s_addr), .rd_data(s_data),
    .fwd_valid(s_fv), .fwd_rd_addr(s_faddr), .fwd_data(s_fdata),
    .wb_err(s_err), .instret(s_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the retire-count model applied, then sample.
  task automatic tick();
    if (m_valid && !stall && !flush) m_cnt = m_cnt + 64'd1;
    if (flush) m_valid = 1'b0;
    else if (!stall) m_valid = in_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic compare();
    exp_t e;
    e = sb_q.pop_front();
    chk("RegWrite", {63'd0, RegWrite}, {63'd0, e.we});
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.we});
    chk("rd_addr", {59'd0, rd_addr}, {59'd0, e.addr});
    chk("fwd_rd_addr", {59'd0, fwd_rd_addr}, {59'd0, e.addr});
    chk("rd_data", {32'd0, rd_data}, {32'd0, e.data});
    chk("fwd_data", {32'd0, fwd_data}, {32'd0, e.data});
    chk("wb_err", {63'd0, wb_err}, {63'd0, e.err});
    chk("instret", instret, m_cnt);
    chk("instret_wrap4", {60'd0, s_instret}, {60'd0, m_cnt[3:0]});
  endtask

  task automatic send(input logic v, input logic rw, input logic [4:0] rd,
                      input logic [1:0] src, input logic [2:0] f3,
                      input logic [31:0] alu, input logic [31:0] rdata,
                      input logic [31:0] pc, input logic e_we,
                      input logic [31:0] e_data, input logic e_err);
    exp_t e;
    stall = 1'b0; flush = 1'b0;
    in_valid = v; in_reg_write = rw; in_rd_addr = rd; in_result_src = src;
    in_funct3 = f3; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc;
    e.we = e_we; e.addr = rd; e.data = e_data; e.err = e_err;
    last_exp = e;
    sb_q.push_back(e);
    tick();
    compare();
  endtask

  // Stall for n cycles while presenting a different entry; outputs must hold.
  task automatic hold(input int n);
    stall = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd3; in_result_src = 2'b00;
    in_alu_result = 32'hDEAD_0000;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(last_exp);
      tick();
      compare();
    end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_rd_addr = 5'd0; in_result_src = 2'b00; in_funct3 = 3'b000;
    in_alu_result = 32'd0; in_mem_rdata = 32'd0; in_pc_plus4 = 32'd0;
    m_valid = 1'b0; m_cnt = 64'd0; last_exp = '0;
    #12;
    chk("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_wb_err", {63'd0, wb_err}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    rst = 1'b0;

    // ALU writeback
    send(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 1'b0);
    // Loads from 0x80FF_7F01
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 32'd0, 1'b1, 32'hFFFF_FF80, 1'b0);
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b100, 32'h0000_0002, 32'h80FF_7F01, 32'd0, 1'b1, 32'h0000_00FF, 1'b0);
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_0002, 32'h80FF_7F01, 32'd0, 1'b1, 32'hFFFF_80FF, 1'b0);
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b001, 32'h0000_0003, 32'h80FF_7F01, 32'd0, 1'b1, 32'hFFFF_80FF, 1'b0);
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_0000, 32'h80FF_7F01, 32'd0, 1'b1, 32'h0000_7F01, 1'b0);
    send(1'b1, 1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_0003, 32'h80FF_7F01, 32'd0, 1'b1, 32'h80FF_7F01, 1'b0);
    send(1'b1, 1'b1, 5'd8, 2'b01, 3'b000, 32'h0000_0001, 32'h80FF_7F01, 32'd0, 1'b1, 32'h0000_007F, 1'b0);
    // PC+4 link
    send(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0055, 32'd0, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0);
    // x0 write is never signalled but still retires
    send(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_0055, 32'd0, 32'd0, 1'b0, 32'h0000_0055, 1'b0);
    // Illegal load funct3, then a clean entry to show the pulse ends
    send(1'b1, 1'b1, 5'd7, 2'b01, 3'b011, 32'h0000_0000, 32'h80FF_7F01, 32'd0, 1'b0, 32'h0000_0000, 1'b1);
    send(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0042, 32'd0, 32'd0, 1'b1, 32'h0000_0042, 1'b0);
    send(1'b1, 1'b1, 5'd7, 2'b01, 3'b111, 32'h0000_0000, 32'h80FF_7F01, 32'd0, 1'b0, 32'h0000_0000, 1'b1);
    // Reserved result source
    send(1'b1, 1'b1, 5'd7, 2'b11, 3'b000, 32'h0000_0042, 32'd0, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b1);
    // Invalid entries neither write nor flag errors
    send(1'b0, 1'b1, 5'd7, 2'b11, 3'b000, 32'h0000_0042, 32'd0, 32'd0, 1'b0, 32'h0000_0000, 1'b0);
    send(1'b1, 1'b0, 5'd7, 2'b00, 3'b000, 32'h0000_0042, 32'd0, 32'd0, 1'b0, 32'h0000_0042, 1'b0);

    // Stall 3 cycles: outputs held, count only after release
    send(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_ABCD, 32'd0, 32'd0, 1'b1, 32'h0000_ABCD, 1'b0);
    hold(3);
    send(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'h0000_0010, 32'd0, 32'd0, 1'b1, 32'h0000_0010, 1'b0);

    // Stall and flush together: entry killed, not counted
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_rd_addr = 5'd11;
    last_exp.we = 1'b0; last_exp.err = 1'b0;
    sb_q.push_back(last_exp);
    tick();
    compare();
    send(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_0012, 32'd0, 32'd0, 1'b1, 32'h0000_0012, 1'b0);
    send(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_0013, 32'd0, 32'd0, 1'b1, 32'h0000_0013, 1'b0);

    // Async reset between edges while stalled: immediate clear, entry discarded
    stall = 1'b1; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("arst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("arst_instret", instret, 64'd0);
    chk("arst_instret4", {60'd0, s_instret}, 64'd0);
    chk("arst_rd_data", {32'd0, rd_data}, 64'd0);
    rst = 1'b0;
    m_valid = 1'b0; m_cnt = 64'd0;
    send(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    send(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
